// File: rtl/mem_access_pkg.sv
// Shared state encoding and address/lane widths for the CPU data-memory access unit.
// Imported by the unit and its byte-lane helper.
package mem_access_pkg;
  localparam int WORD_ADDR_W = 8;
  localparam int LANE_W      = 2;
  localparam int DATA_W      = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/mem_access_unit_byte_lane_merge.sv
// Byte-lane extract (zero-extended, little-endian) and byte insert into a 32-bit word.
// Purely combinational, no backpressure.
module byte_lane_merge
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  input  logic [7:0]        wr_byte,
  output logic [DATA_W-1:0] extracted,
  output logic [DATA_W-1:0] merged
);
  always_comb begin
    extracted = '0;
    merged    = word;
    for (int k = 0; k < 4; k++) begin
      if (lane == LANE_W'(k)) begin
        extracted[7:0]    = word[8*k +: 8];
        merged[8*k +: 8]  = wr_byte;
      end
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, 1 cycle error / 2 cycles load & word store / 3 cycles byte store.
// Backpressure: ready only in IDLE; response held until resp_ready_in.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 11
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   req_valid_in,
  output logic                   req_ready_out,
  input  logic                   req_write_in,
  input  logic                   req_byte_in,
  input  logic [9:0]             req_addr_in,
  input  logic [DATA_W-1:0]      req_wdata_in,
  output logic                   resp_valid_out,
  input  logic                   resp_ready_in,
  output logic [DATA_W-1:0]      resp_rdata_out,
  output logic                   resp_err_out,
  output logic                   mem_write_en_out,
  output logic [WORD_ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0]      mem_data_out,
  input  logic [DATA_W-1:0]      mem_data_in
);
  state_t                  state_q, state_d;
  logic [WORD_ADDR_W-1:0]  addr_q;
  logic [LANE_W-1:0]       lane_q;
  logic                    write_q, byte_q, err_q;
  logic [DATA_W-1:0]       wdata_q, rdata_q, merge_q;
  logic [DATA_W-1:0]       lane_word, merged_word;
  logic                    accept, req_err, word_store;

  assign accept     = req_valid_in && req_ready_out;
  assign req_err    = (!req_byte_in && (req_addr_in[1:0] != 2'b00)) ||
                      (32'(req_addr_in[9:2]) >= MEM_WORDS);
  assign word_store = write_q && !byte_q;

  byte_lane_merge u_lane (
    .word      (mem_data_in),
    .lane      (lane_q),
    .wr_byte   (wdata_q[7:0]),
    .extracted (lane_word),
    .merged    (merged_word)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    req_ready_out    = 1'b0;
    resp_valid_out   = 1'b0;
    mem_write_en_out = 1'b0;
    mem_data_out     = '0;
    case (state_q)
      IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) state_d = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (word_store) begin
          mem_write_en_out = 1'b1;
          mem_data_out     = wdata_q;
        end
        state_d = (write_q && byte_q) ? WRITE : RESP;
      end
      WRITE: begin
        mem_write_en_out = 1'b1;
        mem_data_out     = merge_q;
        state_d          = RESP;
      end
      RESP: begin
        resp_valid_out = 1'b1;
        if (resp_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset arriving mid-store must never let the strobe through.
    if (rst_in) mem_write_en_out = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q  <= '0;
      lane_q  <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr_in[9:2];
      lane_q  <= req_addr_in[1:0];
      write_q <= req_write_in;
      byte_q  <= req_byte_in;
      wdata_q <= req_wdata_in;
      err_q   <= req_err;
      rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      if (!write_q)    rdata_q <= byte_q ? lane_word : mem_data_in;
      else if (byte_q) merge_q <= merged_word;
    end
  end

  assign mem_addr_out   = addr_q;
  assign resp_rdata_out = rdata_q;
  assign resp_err_out   = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written reset/backpressure sequences,
// and random traffic against a word-array reference model.
module tb_mem_access_unit;
  localparam int MEM_WORDS = 11;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req_valid_in, req_ready_out, req_write_in, req_byte_in;
  logic [9:0]  req_addr_in;
  logic [31:0] req_wdata_in;
  logic        resp_valid_out, resp_ready_in, resp_err_out;
  logic [31:0] resp_rdata_out;
  logic        mem_write_en_out;
  logic [7:0]  mem_addr_out;
  logic [31:0] mem_data_out, mem_data_in;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .req_write_in     (req_write_in),
    .req_byte_in      (req_byte_in),
    .req_addr_in      (req_addr_in),
    .req_wdata_in     (req_wdata_in),
    .resp_valid_out   (resp_valid_out),
    .resp_ready_in    (resp_ready_in),
    .resp_rdata_out   (resp_rdata_out),
    .resp_err_out     (resp_err_out),
    .mem_write_en_out (mem_write_en_out),
    .mem_addr_out     (mem_addr_out),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in)
  );

  always #5 clk_in = ~clk_in;

  assign mem_data_in = mem[mem_addr_out];

  always @(posedge clk_in) begin
    if (mem_write_en_out) begin
      mem[mem_addr_out] <= mem_data_out;
      wr_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: memory as an array of words, byte lanes handled with shifts and masks.
  function automatic void model(input logic wr, input logic by, input logic [9:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic err, output int lat);
    int w;
    int k;
    w   = int'(a[9:2]);
    k   = int'(a[1:0]);
    err = (!by && k != 0) || (w >= MEM_WORDS);
    rd  = 32'h0;
    if (err) lat = 1;
    else if (wr) begin
      if (by) begin
        ref_mem[w] = (ref_mem[w] & ~(32'hFF << (8*k))) | ({24'h0, wd[7:0]} << (8*k));
        lat = 3;
      end else begin
        ref_mem[w] = wd;
        lat = 2;
      end
    end else begin
      rd  = by ? ((ref_mem[w] >> (8*k)) & 32'hFF) : ref_mem[w];
      lat = 2;
    end
  endfunction

  task automatic do_txn(input logic wr, input logic by, input logic [9:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int hold);
    int lat;
    int wr0;
    @(negedge clk_in);
    check("ready_before_req", {31'h0, req_ready_out}, 32'h1);
    req_valid_in = 1'b1;
    req_write_in = wr;
    req_byte_in  = by;
    req_addr_in  = a;
    req_wdata_in = wd;
    wr0 = wr_count;
    @(posedge clk_in);
    #1 req_valid_in = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_in);
      lat++;
    end while (!resp_valid_out && lat < 10);
    check("latency", lat, exp_lat);
    check("rdata", resp_rdata_out, exp_rd);
    check("err", {31'h0, resp_err_out}, {31'h0, exp_err});
    check("ready_in_resp", {31'h0, req_ready_out}, 32'h0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_in);
      check("hold_valid", {31'h0, resp_valid_out}, 32'h1);
      check("hold_rdata", resp_rdata_out, exp_rd);
      check("hold_err", {31'h0, resp_err_out}, {31'h0, exp_err});
      check("hold_ready", {31'h0, req_ready_out}, 32'h0);
    end
    resp_ready_in = 1'b1;
    @(posedge clk_in);
    #1 resp_ready_in = 1'b0;
    @(negedge clk_in);
    check("idle_after_resp", {31'h0, req_ready_out}, 32'h1);
    check("valid_drop", {31'h0, resp_valid_out}, 32'h0);
    check("write_count", wr_count - wr0, (wr && !exp_err) ? 1 : 0);
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    #1 check("wen_in_reset", {31'h0, mem_write_en_out}, 32'h0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_ready", {31'h0, req_ready_out}, 32'h1);
    check("rst_valid", {31'h0, resp_valid_out}, 32'h0);
    check("rst_err", {31'h0, resp_err_out}, 32'h0);
    check("rst_rdata", resp_rdata_out, 32'h0);
    check("rst_addr", {24'h0, mem_addr_out}, 32'h0);
    check("rst_mdata", mem_data_out, 32'h0);
    check("rst_wen", {31'h0, mem_write_en_out}, 32'h0);
  endtask

  typedef struct {
    logic        wr;
    logic        by;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat;
    int          wr0;
    logic [9:0]  ra;
    logic        rwr, rby;
    logic [31:0] rwd;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst_in = 1'b1; req_valid_in = 1'b0; req_write_in = 1'b0; req_byte_in = 1'b0;
    req_addr_in = '0; req_wdata_in = '0; resp_ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    apply_reset();

    vecs[0]  = '{1'b1, 1'b0, 10'h008, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0};
    vecs[1]  = '{1'b0, 1'b0, 10'h008, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
    vecs[2]  = '{1'b1, 1'b1, 10'h009, 32'hFFFFFF5A, 32'h0,        1'b0, 3, 0};
    vecs[3]  = '{1'b0, 1'b1, 10'h009, 32'h0,        32'h0000005A, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 1'b0, 10'h008, 32'h0,        32'hDEAD5AEF, 1'b0, 2, 5};
    vecs[5]  = '{1'b0, 1'b0, 10'h006, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[6]  = '{1'b0, 1'b0, 10'h02C, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[7]  = '{1'b0, 1'b1, 10'h00B, 32'h0,        32'h000000DE, 1'b0, 2, 0};
    vecs[8]  = '{1'b1, 1'b1, 10'h028, 32'h12345677, 32'h0,        1'b0, 3, 0};
    vecs[9]  = '{1'b0, 1'b0, 10'h028, 32'h0,        32'h00000077, 1'b0, 2, 2};
    vecs[10] = '{1'b0, 1'b1, 10'h02D, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[11] = '{1'b1, 1'b0, 10'h003, 32'hCAFEF00D, 32'h0,        1'b1, 1, 0};

    for (int i = 0; i < 12; i++) begin
      model(vecs[i].wr, vecs[i].by, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_lat);
      do_txn(vecs[i].wr, vecs[i].by, vecs[i].addr, vecs[i].wdata,
             vecs[i].rd, vecs[i].err, vecs[i].lat, vecs[i].hold);
    end
    check("mem_word2", mem[2], 32'hDEAD5AEF);

    // Reset while the merged byte is about to be written.
    wr0 = wr_count;
    @(negedge clk_in);
    req_valid_in = 1'b1; req_write_in = 1'b1; req_byte_in = 1'b1;
    req_addr_in = 10'h00A; req_wdata_in = 32'h000000AA;
    @(posedge clk_in);
    #1 req_valid_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("in_write_wen", {31'h0, mem_write_en_out}, 32'h1);
    rst_in = 1'b1;
    #1 check("rst_write_wen", {31'h0, mem_write_en_out}, 32'h0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_write_nowrite", wr_count - wr0, 0);
    check("rst_write_word", mem[2], 32'hDEAD5AEF);
    check("rst_write_valid", {31'h0, resp_valid_out}, 32'h0);
    check("rst_write_ready", {31'h0, req_ready_out}, 32'h1);

    // Reset during ACCESS of a word store.
    @(negedge clk_in);
    req_valid_in = 1'b1; req_write_in = 1'b1; req_byte_in = 1'b0;
    req_addr_in = 10'h004; req_wdata_in = 32'h11223344;
    @(posedge clk_in);
    #1 req_valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    #1 check("rst_access_wen", {31'h0, mem_write_en_out}, 32'h0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_access_nowrite", wr_count - wr0, 0);
    check("rst_access_word", mem[1], ref_mem[1]);
    check("rst_access_valid", {31'h0, resp_valid_out}, 32'h0);

    for (int n = 0; n < 250; n++) begin
      rwr = 1'($urandom_range(0, 1));
      rby = 1'($urandom_range(0, 1));
      ra  = 10'($urandom_range(0, 4*MEM_WORDS + 7));
      rwd = $urandom;
      model(rwr, rby, ra, rwd, m_rd, m_err, m_lat);
      do_txn(rwr, rby, ra, rwd, m_rd, m_err, m_lat, $urandom_range(0, 3));
    end

    for (int i = 0; i < MEM_WORDS + 2; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
